pipelined_barrel_shifter: RTL
=============================

// Module: pipelined_barrel_shifter
// PURPOSE
//   Parametrised, pipelined barrel shifter for the ALU datapath. Supports logical left,
//   logical right, arithmetic right and rotate right. One log2 stage per pipeline
//   register, so throughput is 1 op/cycle at high Fmax. Valid/ready handshake on both
//   sides, with full backpressure. Feeds the ALU result mux in the multicycle/pipelined core.
// PARAMETERS
//   N  32  data width; power of two, >= 4
//   L  $clog2(N)  derived localparam: number of shift stages = pipeline latency
// PORTS
//   clk        in   1          rising-edge clock
//   rst        in   1          synchronous reset, active high
//   in_valid   in   1          upstream has an op
//   in_ready   out  1          shifter accepts op this cycle
//   in_data    in   N          operand
//   in_shamt   in   $clog2(N)  shift amount, unsigned
//   in_op      in   2          shift_op_t: 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   out_valid  out  1          result available
//   out_ready  in   1          downstream accepts result
//   out_data   out  N          shifted result
// BEHAVIOUR
//   - Reset: all stage valid bits 0, all stage data/shamt/op regs 0; out_valid=0, out_data=0.
//     Reset mid-operation flushes every in-flight op; nothing is emitted afterwards.
//   - Handshake: transfer when valid&&ready on the same edge. advance = out_ready || !out_valid;
//     in_ready = advance (combinational, no dependence on in_valid). When advance=0 the
//     whole pipe holds, and out_data/out_valid stay stable until accepted.
//   - Stage k (k=0..L-1) takes data, shamt, op and valid from stage k-1 (stage -1 = inputs).
//     If shamt[k]=1, it shifts by 2**k per op, otherwise it passes data through. shamt/op
//     travel with the data.
//   - Fill rules per stage: SLL low bits <- 0; SRL high bits <- 0; SRA high bits <- data[N-1]
//     of the stage input (sign is preserved because the MSB is invariant under SRA);
//     ROR bits leaving bit 0 re-enter at bit N-1.
//   - Latency: exactly L cycles from accepted input to out_valid with out_ready held 1;
//     back-to-back ops give one result per cycle, and results leave in order.
//   - Bubbles are not collapsed while stalled: when advance=0, every stage holds, even empty ones.
//   - shamt=0 -> out_data==in_data for all ops. shamt=N-1 for SRL -> {0..0,in[N-1]}.
//   - Simultaneous accept at input and output in the same cycle is legal and is the steady state.
//   - Invalid stages still clock data (don't-care), but their valid bit is 0. out_data is only
//     meaningful when out_valid=1.
// STRUCTURE
//   - shifter_pkg: typedef enum logic [1:0] shift_op_t {SHIFT_SLL, SHIFT_SRL, SHIFT_SRA,
//     SHIFT_ROR}; function automatic shift_stage(data, op, amt) used for reference modelling.
//   - Sub-module shifter_stage #(N, K): one log stage, a combinational 4-way op mux and
//     shift by 2**K, registered under enable/rst. Top level is a generate loop of L
//     shifter_stage instances plus the advance/in_ready logic.
// TESTING
//   1 Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, out_data=0 throughout,
//     nothing emitted for 2*L cycles.
//   2 N=32, out_ready=1: SLL 0x0000_0001 by 31 -> 0x8000_0000; SRL 0x8000_0000 by 31
//     -> 0x0000_0001; each after exactly 5 cycles.
//   3 SRA 0x8000_00F0 by 4 -> 0xF800_000F; ROR 0x0000_000F by 4 -> 0xF000_0000;
//     any op with shamt=0 -> input unchanged.
//   4 Stream of 8 random ops with out_ready=1 -> 8 consecutive out_valid cycles, results
//     match the shifter_pkg model and stay in order.
//   5 Backpressure: drop out_ready for 3 cycles while the pipe is full -> in_ready=0,
//     out_data stable; no op lost or duplicated after release.
//   6 Assert rst with 3 ops in flight -> out_valid stays 0, and the next op after reset
//     emerges L cycles after it is accepted.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter plus a whole-amount shift
// function that serves as the behavioural reference for the pipeline.
package shifter_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_op_t;

    localparam int unsigned MODEL_N = 32;

    // Applies the full shift amount in one step, independent of the log-stage split.
    function automatic logic [MODEL_N-1:0] shift_stage(input logic [MODEL_N-1:0] data,
                                                       input shift_op_t op,
                                                       input int unsigned amt);
        logic [2*MODEL_N-1:0] dbl;
        logic [MODEL_N-1:0]   res;
        dbl = {data, data} >> amt;
        case (op)
            SHIFT_SLL: res = data << amt;
            SHIFT_SRL: res = data >> amt;
            SHIFT_SRA: res = $unsigned($signed(data) >>> amt);
            default:   res = dbl[MODEL_N-1:0];
        endcase
        return res;
    endfunction

endpackage

// File: rtl/shifter_stage.sv
// One log stage of the barrel shifter: shifts by 2**K when shamt bit K is set,
// then registers data/shamt/op/valid under the pipeline-wide enable.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int N = 32,
    parameter int K = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 valid_i,
    input  logic [N-1:0]         data_i,
    input  logic [$clog2(N)-1:0] shamt_i,
    input  shift_op_t            op_i,
    output logic                 valid_o,
    output logic [N-1:0]         data_o,
    output logic [$clog2(N)-1:0] shamt_o,
    output shift_op_t            op_o
);
    localparam int S = 2 ** K;

    logic                 valid_q;
    logic [N-1:0]         data_q;
    logic [N-1:0]         data_d;
    logic [N-1:0]         shifted;
    logic [$clog2(N)-1:0] shamt_q;
    shift_op_t            op_q;

    always_comb begin
        shifted = data_i;
        case (op_i)
            SHIFT_SLL: shifted = {data_i[N-1-S:0], {S{1'b0}}};
            SHIFT_SRL: shifted = {{S{1'b0}}, data_i[N-1:S]};
            SHIFT_SRA: shifted = {{S{data_i[N-1]}}, data_i[N-1:S]};
            SHIFT_ROR: shifted = {data_i[S-1:0], data_i[N-1:S]};
            default:   shifted = data_i;
        endcase
        data_d = shamt_i[K] ? shifted : data_i;
    end

    // Reset takes priority over enable so a stalled pipe is still flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            op_q    <= SHIFT_SLL;
        end else if (en) begin
            valid_q <= valid_i;
            data_q  <= data_d;
            shamt_q <= shamt_i;
            op_q    <= op_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign shamt_o = shamt_q;
    assign op_o    = op_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one registered log stage per shift-amount bit,
// whole pipe advances together under valid/ready backpressure.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_data,
    input  logic [$clog2(N)-1:0] in_shamt,
    input  logic [1:0]           in_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_data
);
    localparam int L = $clog2(N);

    // Handshake: a transfer happens on any edge where valid and ready are both 1.
    // The pipe moves only when the output slot is empty or being drained, and
    // in_ready mirrors that without looking at in_valid.
    logic advance;

    logic                 valid_c [L+1];
    logic [N-1:0]         data_c  [L+1];
    logic [$clog2(N)-1:0] shamt_c [L+1];
    shift_op_t            op_c    [L+1];

    assign advance  = out_ready || !out_valid;
    assign in_ready = advance;

    assign valid_c[0] = in_valid;
    assign data_c[0]  = in_data;
    assign shamt_c[0] = in_shamt;
    assign op_c[0]    = shift_op_t'(in_op);

    for (genvar k = 0; k < L; k++) begin : g_stage
        shifter_stage #(.N(N), .K(k)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (advance),
            .valid_i (valid_c[k]),
            .data_i  (data_c[k]),
            .shamt_i (shamt_c[k]),
            .op_i    (op_c[k]),
            .valid_o (valid_c[k+1]),
            .data_o  (data_c[k+1]),
            .shamt_o (shamt_c[k+1]),
            .op_o    (op_c[k+1])
        );
    end

    assign out_valid = valid_c[L];
    assign out_data  = data_c[L];

    // Shamt/op have no consumer past the last stage.
    logic unused_tail;
    assign unused_tail = ^{shamt_c[L], op_c[L]};

endmodule
